// File: rtl/pci_phy_pkg.sv
// Shared PCIe PHY datapath constants and lane helpers, used by mux_32_8 and demux_8_32.
package pci_phy_pkg;
   localparam int WORD_W = 32;
   localparam int LANE_W = 8;
   localparam int LANES  = 4;
   localparam int IDX_W  = $clog2(LANES);

   // Byte k of a word in transmit order; MSB-first counts lanes down from the top.
   function automatic logic [LANE_W-1:0] lane_sel(input logic [WORD_W-1:0] word,
                                                   input logic [IDX_W-1:0]  k,
                                                   input logic              msb_first);
      logic [IDX_W-1:0] pos;
      pos = msb_first ? (IDX_W'(LANES - 1) - k) : k;
      return word[pos*LANE_W +: LANE_W];
   endfunction
endpackage

// File: rtl/word_hold_reg.sv
// One-word holding register that lets the serializer take the next word while
// the current one is still shifting out.
module word_hold_reg
   import pci_phy_pkg::*;
(
   input  logic              clk_4f,
   input  logic              reset,
   input  logic              load,
   input  logic              clear,
   input  logic [WORD_W-1:0] d,
   output logic [WORD_W-1:0] q,
   output logic              valid
);

   // Occupancy flag; load wins over clear, although the top never asks for both.
   always_ff @(posedge clk_4f) begin
      if (!reset) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
      end else if (clear) begin
         valid <= 1'b0;
      end else begin
         valid <= valid;
      end
   end

   // Data payload; contents are meaningless while valid is low, so no reset.
   always_ff @(posedge clk_4f) begin
      if (load) begin
         q <= d;
      end else begin
         q <= q;
      end
   end

endmodule

// File: rtl/mux_32_8.sv
// Word-to-byte serializer: 32-bit valid/ready words out as four aligned,
// contiguous bytes at the clk_4f rate with a byte-valid qualifier.
module mux_32_8
   import pci_phy_pkg::*;
#(
   parameter logic              MSB_FIRST = 1'b1,
   parameter logic [LANE_W-1:0] IDLE_BYTE = 8'h00
) (
   input  logic              clk_4f,
   input  logic              reset,
   input  logic [WORD_W-1:0] data_in,
   input  logic              valid_in,
   output logic              ready_out,
   output logic [LANE_W-1:0] data_out,
   output logic              valid_out
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

   logic [WORD_W-1:0] sreg_r;
   logic [WORD_W-1:0] sreg_nxt_s;
   logic [WORD_W-1:0] pend_s;
   logic [IDX_W-1:0]  cnt_r;
   logic [IDX_W-1:0]  cnt_nxt_s;
   logic              busy_r;
   logic              busy_nxt_s;
   logic              pend_valid_s;
   logic              pend_load_s;
   logic              pend_clear_s;
   logic              accept_s;
   logic [LANE_W-1:0] data_nxt_s;
   logic              valid_nxt_s;

   // No path from valid_in: ready depends only on reset and the holding flag.
   assign ready_out = reset & ~pend_valid_s;
   assign accept_s  = valid_in & ready_out;

   word_hold_reg u_hold (
      .clk_4f (clk_4f),
      .reset  (reset),
      .load   (pend_load_s),
      .clear  (pend_clear_s),
      .d      (data_in),
      .q      (pend_s),
      .valid  (pend_valid_s)
   );

   // IDLE/SEND control and next-byte selection.
   always_comb begin
      sreg_nxt_s   = sreg_r;
      cnt_nxt_s    = cnt_r;
      busy_nxt_s   = busy_r;
      data_nxt_s   = IDLE_BYTE;
      valid_nxt_s  = 1'b0;
      pend_load_s  = 1'b0;
      pend_clear_s = 1'b0;
      if (!busy_r) begin
         if (accept_s) begin
            sreg_nxt_s  = data_in;
            data_nxt_s  = lane_sel(data_in, '0, MSB_FIRST);
            valid_nxt_s = 1'b1;
            cnt_nxt_s   = '0;
            busy_nxt_s  = 1'b1;
         end else begin
            busy_nxt_s = 1'b0;
         end
      end else if (cnt_r != LAST_IDX) begin
         cnt_nxt_s   = cnt_r + IDX_W'(1);
         data_nxt_s  = lane_sel(sreg_r, cnt_r + IDX_W'(1), MSB_FIRST);
         valid_nxt_s = 1'b1;
         pend_load_s = accept_s;
      end else if (pend_valid_s) begin
         sreg_nxt_s   = pend_s;
         data_nxt_s   = lane_sel(pend_s, '0, MSB_FIRST);
         valid_nxt_s  = 1'b1;
         cnt_nxt_s    = '0;
         pend_clear_s = 1'b1;
      end else if (accept_s) begin
         sreg_nxt_s  = data_in;
         data_nxt_s  = lane_sel(data_in, '0, MSB_FIRST);
         valid_nxt_s = 1'b1;
         cnt_nxt_s   = '0;
      end else begin
         busy_nxt_s = 1'b0;
      end
   end

   // State and registered byte outputs; reset drops any word in flight.
   always_ff @(posedge clk_4f) begin
      if (!reset) begin
         sreg_r    <= '0;
         cnt_r     <= '0;
         busy_r    <= 1'b0;
         data_out  <= IDLE_BYTE;
         valid_out <= 1'b0;
      end else begin
         sreg_r    <= sreg_nxt_s;
         cnt_r     <= cnt_nxt_s;
         busy_r    <= busy_nxt_s;
         data_out  <= data_nxt_s;
         valid_out <= valid_nxt_s;
      end
   end

endmodule

// File: tb/tb_mux_32_8.sv
// Directed self-checking bench for mux_32_8 (MSB-first and LSB-first instances).
module tb_mux_32_8;
   logic        clk_4f = 1'b0;
   logic        reset;
   logic [31:0] data_in;
   logic        valid_in;
   logic        ready_out;
   logic [7:0]  data_out;
   logic        valid_out;
   logic        lsb_ready;
   logic [7:0]  lsb_data;
   logic        lsb_valid;

   int n_tot = 0;
   int n_bad = 0;

   logic [31:0] wq[$];
   int          sq[$];
   logic [7:0]  rx[$];
   logic [7:0]  rx_lsb[$];
   int          rdy_low, rises, idle_bad;

   mux_32_8 #(.MSB_FIRST(1'b1), .IDLE_BYTE(8'h00)) u_dut (
      .clk_4f(clk_4f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
      .ready_out(ready_out), .data_out(data_out), .valid_out(valid_out));

   mux_32_8 #(.MSB_FIRST(1'b0), .IDLE_BYTE(8'h00)) u_lsb (
      .clk_4f(clk_4f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
      .ready_out(lsb_ready), .data_out(lsb_data), .valid_out(lsb_valid));

   always #5 clk_4f = ~clk_4f;

   // Presents wq[i] from loop cycle sq[i] onward, honours ready, records output bytes.
   task automatic drive_and_collect(input int cycles);
      int   idx;
      logic rdy_prev;
      logic prev_v;
      idx = 0; rdy_prev = ready_out; prev_v = valid_out;
      rx.delete(); rx_lsb.delete();
      rdy_low = 0; rises = 0; idle_bad = 0;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk_4f);
         if (valid_in && rdy_prev) idx++;
         if (valid_out) begin
            rx.push_back(data_out);
            if (!prev_v) rises++;
         end else if (data_out !== 8'h00) begin
            idle_bad++;
         end
         if (lsb_valid) rx_lsb.push_back(lsb_data);
         if (!ready_out) rdy_low++;
         prev_v = valid_out;
         rdy_prev = ready_out;
         if (idx < wq.size() && c >= sq[idx]) begin
            valid_in = 1'b1; data_in = wq[idx];
         end else begin
            valid_in = 1'b0; data_in = 32'h0;
         end
      end
      valid_in = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; valid_in = 1'b1; data_in = 32'hDEADBEEF;
      repeat (3) @(negedge clk_4f);
      n_tot++;
      if (valid_out !== 1'b0 || data_out !== 8'h00) begin
         n_bad++; $display("FAIL reset_out: got v=%b d=%h want v=0 d=00", valid_out, data_out);
      end
      n_tot++;
      if (ready_out !== 1'b0 || lsb_ready !== 1'b0) begin
         n_bad++; $display("FAIL reset_ready: got %b/%b want 0/0", ready_out, lsb_ready);
      end
      reset = 1'b1; valid_in = 1'b0; data_in = 32'h0;
      #1;
      n_tot++;
      if (ready_out !== 1'b1) begin
         n_bad++; $display("FAIL ready_after_reset: got %b want 1", ready_out);
      end
   endtask

   task automatic test_single();
      logic [7:0] exp_b [4] = '{8'hEE, 8'hFF, 8'hFD, 8'hCC};
      logic [7:0] got;
      wq = '{32'hEEFFFDCC}; sq = '{0};
      drive_and_collect(8);
      n_tot++;
      if (rx.size() != 4) begin
         n_bad++; $display("FAIL single_count: got %0d want 4", rx.size());
      end
      for (int i = 0; i < 4; i++) begin
         got = (i < rx.size()) ? rx[i] : 8'hxx;
         n_tot++;
         if (got !== exp_b[i]) begin
            n_bad++; $display("FAIL single_byte%0d: got %h want %h", i, got, exp_b[i]);
         end
      end
      n_tot++;
      if (rises != 1 || idle_bad != 0) begin
         n_bad++; $display("FAIL single_shape: got rises=%0d idle_bad=%0d want 1/0", rises, idle_bad);
      end
      n_tot++;
      if (valid_out !== 1'b0 || data_out !== 8'h00) begin
         n_bad++; $display("FAIL single_idle: got v=%b d=%h want v=0 d=00", valid_out, data_out);
      end
   endtask

   task automatic test_lsb_first();
      logic [7:0] exp_b [4] = '{8'hCC, 8'hFD, 8'hFF, 8'hEE};
      logic [7:0] got;
      wq = '{32'hEEFFFDCC}; sq = '{0};
      drive_and_collect(8);
      n_tot++;
      if (rx_lsb.size() != 4) begin
         n_bad++; $display("FAIL lsb_count: got %0d want 4", rx_lsb.size());
      end
      for (int i = 0; i < 4; i++) begin
         got = (i < rx_lsb.size()) ? rx_lsb[i] : 8'hxx;
         n_tot++;
         if (got !== exp_b[i]) begin
            n_bad++; $display("FAIL lsb_byte%0d: got %h want %h", i, got, exp_b[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_b [8] = '{8'hAA, 8'h12, 8'hBB, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
      logic [7:0] got;
      wq = '{32'hAA12BB00, 32'h11223344}; sq = '{0, 0};
      drive_and_collect(14);
      n_tot++;
      if (rx.size() != 8) begin
         n_bad++; $display("FAIL b2b_count: got %0d want 8", rx.size());
      end
      for (int i = 0; i < 8; i++) begin
         got = (i < rx.size()) ? rx[i] : 8'hxx;
         n_tot++;
         if (got !== exp_b[i]) begin
            n_bad++; $display("FAIL b2b_byte%0d: got %h want %h", i, got, exp_b[i]);
         end
      end
      n_tot++;
      if (rises != 1 || rdy_low != 3) begin
         n_bad++; $display("FAIL b2b_shape: got rises=%0d rdy_low=%0d want 1/3", rises, rdy_low);
      end
   endtask

   task automatic test_three_words();
      logic [7:0] exp_b [12] = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60,
                                 8'h70, 8'h80, 8'h90, 8'hA0, 8'hB0, 8'hC0};
      logic [7:0] got;
      wq = '{32'h10203040, 32'h50607080, 32'h90A0B0C0}; sq = '{0, 0, 0};
      drive_and_collect(20);
      n_tot++;
      if (rx.size() != 12) begin
         n_bad++; $display("FAIL three_count: got %0d want 12", rx.size());
      end
      for (int i = 0; i < 12; i++) begin
         got = (i < rx.size()) ? rx[i] : 8'hxx;
         n_tot++;
         if (got !== exp_b[i]) begin
            n_bad++; $display("FAIL three_byte%0d: got %h want %h", i, got, exp_b[i]);
         end
      end
      n_tot++;
      if (rises != 1 || rdy_low != 6) begin
         n_bad++; $display("FAIL three_shape: got rises=%0d rdy_low=%0d want 1/6", rises, rdy_low);
      end
   endtask

   task automatic test_direct_load();
      logic [7:0] exp_b [8] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h55, 8'h66, 8'h77, 8'h88};
      logic [7:0] got;
      wq = '{32'hA1B2C3D4, 32'h55667788}; sq = '{0, 4};
      drive_and_collect(14);
      n_tot++;
      if (rx.size() != 8) begin
         n_bad++; $display("FAIL direct_count: got %0d want 8", rx.size());
      end
      for (int i = 0; i < 8; i++) begin
         got = (i < rx.size()) ? rx[i] : 8'hxx;
         n_tot++;
         if (got !== exp_b[i]) begin
            n_bad++; $display("FAIL direct_byte%0d: got %h want %h", i, got, exp_b[i]);
         end
      end
      n_tot++;
      if (rises != 1 || rdy_low != 0) begin
         n_bad++; $display("FAIL direct_shape: got rises=%0d rdy_low=%0d want 1/0", rises, rdy_low);
      end
   endtask

   task automatic test_gap();
      logic [7:0] exp_b [8] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h0B, 8'hAD, 8'hF0, 8'h0D};
      logic [7:0] got;
      wq = '{32'hDEADBEEF, 32'h0BADF00D}; sq = '{0, 6};
      drive_and_collect(14);
      n_tot++;
      if (rx.size() != 8) begin
         n_bad++; $display("FAIL gap_count: got %0d want 8", rx.size());
      end
      for (int i = 0; i < 8; i++) begin
         got = (i < rx.size()) ? rx[i] : 8'hxx;
         n_tot++;
         if (got !== exp_b[i]) begin
            n_bad++; $display("FAIL gap_byte%0d: got %h want %h", i, got, exp_b[i]);
         end
      end
      n_tot++;
      if (rises != 2 || idle_bad != 0) begin
         n_bad++; $display("FAIL gap_shape: got rises=%0d idle_bad=%0d want 2/0", rises, idle_bad);
      end
   endtask

   task automatic test_mid_reset();
      logic [7:0] exp_b [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
      logic [7:0] got;
      valid_in = 1'b1; data_in = 32'hCAFEBABE;
      @(negedge clk_4f);
      valid_in = 1'b0; data_in = 32'h0;
      n_tot++;
      if (valid_out !== 1'b1 || data_out !== 8'hCA) begin
         n_bad++; $display("FAIL mid_byte0: got v=%b d=%h want v=1 d=ca", valid_out, data_out);
      end
      @(negedge clk_4f);
      n_tot++;
      if (valid_out !== 1'b1 || data_out !== 8'hFE) begin
         n_bad++; $display("FAIL mid_byte1: got v=%b d=%h want v=1 d=fe", valid_out, data_out);
      end
      reset = 1'b0;
      @(negedge clk_4f);
      n_tot++;
      if (valid_out !== 1'b0 || data_out !== 8'h00 || ready_out !== 1'b0) begin
         n_bad++; $display("FAIL mid_reset_idle: got v=%b d=%h r=%b want 0/00/0",
                           valid_out, data_out, ready_out);
      end
      reset = 1'b1;
      wq = '{32'h01020304}; sq = '{0};
      drive_and_collect(8);
      n_tot++;
      if (rx.size() != 4) begin
         n_bad++; $display("FAIL after_reset_count: got %0d want 4", rx.size());
      end
      for (int i = 0; i < 4; i++) begin
         got = (i < rx.size()) ? rx[i] : 8'hxx;
         n_tot++;
         if (got !== exp_b[i]) begin
            n_bad++; $display("FAIL after_reset_byte%0d: got %h want %h", i, got, exp_b[i]);
         end
      end
   endtask

   initial begin
      reset = 1'b0; valid_in = 1'b0; data_in = 32'h0;
      @(negedge clk_4f);
      test_reset();
      test_single();
      test_lsb_first();
      test_back_to_back();
      test_three_words();
      test_direct_load();
      test_gap();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

endmodule

// File: doc/mux_32_8.md
# mux_32_8

Word-to-byte serializer for the PCIe physical-layer datapath; the transmit-side counterpart of `demux_8_32`. It accepts 32-bit words from the link layer through a valid/ready handshake and emits them as four consecutive bytes at the `clk_4f` rate, with a byte-valid qualifier. Byte groups are always emitted aligned and contiguous, so the stream can feed `demux_8_32` directly. A one-word holding register allows back-to-back words without bubbles.

## Interface
Parameters:
- `MSB_FIRST`, 1: 1 = byte [31:24] first; 0 = byte [7:0] first.
- `IDLE_BYTE`, 8'h00: value driven on `data_out` whenever `valid_out`=0.

Ports:
- `clk_4f`  in  1  byte-rate clock; the only clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk_4f`.
- `data_in`  in  32  word to serialize.
- `valid_in`  in  1  `data_in` is valid.
- `ready_out`  out  1  block can accept a word this cycle.
- `data_out`  out  8  serialized byte (registered).
- `valid_out`  out  1  `data_out` is valid (registered).

## Operation
- Accept: a word is accepted at a rising edge with `valid_in`=1, `ready_out`=1 and `reset`=1.
- `ready_out` = `reset` & !`pend_valid`. It is driven from registers only, with no combinational path from `valid_in`.
- State:
  - shift register `sreg[31:0]`
  - byte index `cnt[1:0]` (index of the byte currently on `data_out`)
  - `busy`
  - holding register `pend[31:0]` and `pend_valid`
- IDLE (`busy`=0): on accept, load `sreg`, drive byte 0 on `data_out`, set `valid_out`=1, `cnt`=0, `busy`=1.
- SEND, `cnt`<3:
  - Drive byte `cnt`+1 and increment `cnt`.
  - A word accepted on this edge goes to `pend` and sets `pend_valid`=1.
- SEND, `cnt`=3 (last byte on the output):
  - If `pend_valid`: load `pend`, drive its byte 0, `cnt`=0, clear `pend_valid`.
  - Else if a word is accepted: load it directly, drive its byte 0, `cnt`=0.
  - Else: go to IDLE, `valid_out`=0, `data_out`=`IDLE_BYTE`.
- Byte order: for `MSB_FIRST`=1, byte k = `data_in[31-8k -: 8]`; for `MSB_FIRST`=0, byte k = `data_in[8k +: 8]`.
- `valid_out` never drops inside a word. It can only drop after byte 3.
- Reset (`reset`=0 at an edge):
  - `data_out`=`IDLE_BYTE`, `valid_out`=0, `cnt`=0, `busy`=0, `pend_valid`=0, `ready_out`=0.
  - Any partially sent word and any held word are discarded.
  - `valid_in` is ignored during reset.

## Timing
- Latency: a word accepted at edge n has byte 0 on `data_out` after edge n, and bytes 1..3 after edges n+1..n+3.
- Sustained throughput is one word per 4 cycles with no gaps when `valid_in` stays high.
- `ready_out` falls one cycle after a word is captured into `pend`. It rises after the edge that moves `pend` into `sreg`.
- Worst case: 2 words buffered (`sreg` + `pend`).
- Leaving reset: `ready_out`=1 in the first cycle with `reset`=1. The earliest byte appears after the following edge.
- Reset asserted mid-word: the output is idle after that same edge. No further bytes of that word are ever emitted.

## Structure
- Shared package `pci_phy_pkg`:
  - `WORD_W`=32, `LANE_W`=8, `LANES`=4.
  - Byte-index width.
  - Shared with `demux_8_32`.
- The two-state control (IDLE/SEND) is encoded locally. It is a single `busy` bit, so no typedef is needed.
- One sub-module is natural: `word_hold_reg` (the `pend`/`pend_valid` holding register with load/clear). Everything else stays in `mux_32_8`.

## Test plan
- Single word `0xEEFFFDCC`, `MSB_FIRST`=1 → `data_out` EE, FF, FD, CC on 4 consecutive cycles with `valid_out`=1, then `valid_out`=0 and `data_out`=00.
- Back-to-back `0xAA12BB00`, `0x11223344`, `valid_in` held high → 8 contiguous valid bytes AA 12 BB 00 11 22 33 44. `ready_out` drops for exactly the cycles `pend` is full.
- Three words presented continuously → no word lost or duplicated, 12 contiguous bytes, `ready_out` honored.
- Reset driven low on the cycle after byte 1 of `0xCAFEBABE` → `valid_out`=0 and `data_out`=00 on the next edge. The next word `0x01020304` after reset emits 01 02 03 04 cleanly.
- `MSB_FIRST`=0 with `0xEEFFFDCC` → CC, FD, FF, EE.
- Loopback into `demux_8_32` with the clocks aligned, random words, random `valid_in` gaps → reconstructed words equal the sent words, in order.
